// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the nibble-serial CLA sequencer.
package cla_pkg;
   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;
endpackage

// File: rtl/cla_nibble_seq_ctrl_if.sv
// Operand/result handshake bundle between the operand source and the sequencer.
interface cla_nibble_seq_ctrl_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/complete_circuit.sv
// Registered 4-bit carry-lookahead adder; sum/cout appear one clock after a/b/cin.
module complete_circuit
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);
   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] g;
   logic [NIB_W:0]   c;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c    = '0;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= p ^ c[NIB_W-1:0];
         cout <= c[NIB_W];
      end
   end
endmodule

// File: rtl/cla_nibble_seq_ctrl.sv
// WIDTH-bit adder built by feeding one nibble per clock through an external registered CLA.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   RUN   | feeding nibble idx to the adder, collecting nibble idx-1
//   DRAIN | collecting the top nibble and final carry
//   DONE  | out_valid high until out_ready
module cla_nibble_seq_ctrl
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cla_nibble_seq_ctrl_if.slave  bus,
   output logic [NIB_W-1:0]      add_a,
   output logic [NIB_W-1:0]      add_b,
   output logic                  add_cin,
   input  logic [NIB_W-1:0]      add_sum,
   input  logic                  add_cout
);
   localparam int NUM_NIB = WIDTH / NIB_W;
   localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

   if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_width_check
      $error("cla_nibble_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
   end

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [WIDTH-1:0]       a_q;
   logic [WIDTH-1:0]       b_q;
   logic [WIDTH-1:0]       sum_q;
   logic                   cout_q;
   logic                   cin_q;
   logic                   chain_q;
   logic                   in_ready_q;
   logic                   out_valid_q;

   logic [WIDTH-1:0]       a_next;
   logic [WIDTH-1:0]       b_next;
   logic [WIDTH+NIB_W-1:0] sum_cat;
   logic [WIDTH-1:0]       sum_shift;

   // Operands shift down a nibble per pass; result nibbles enter from the top.
   assign a_next    = a_q >> NIB_W;
   assign b_next    = b_q >> NIB_W;
   assign sum_cat   = {add_sum, sum_q};
   assign sum_shift = sum_cat[WIDTH+NIB_W-1:NIB_W];

   // After nibble 0 the carry comes straight from the adder's registered cout.
   assign add_cin = chain_q ? add_cout : cin_q;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         cin_q       <= 1'b0;
         chain_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         add_a       <= '0;
         add_b       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.in_a;
                  b_q        <= bus.in_b;
                  add_a      <= bus.in_a[NIB_W-1:0];
                  add_b      <= bus.in_b[NIB_W-1:0];
                  cin_q      <= bus.in_cin;
                  chain_q    <= 1'b0;
                  idx        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (idx != '0) begin
                  sum_q <= sum_shift;
               end
               cin_q <= 1'b0;
               if (idx == LAST_IDX) begin
                  add_a   <= '0;
                  add_b   <= '0;
                  chain_q <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  idx     <= idx + 1'b1;
                  a_q     <= a_next;
                  b_q     <= b_next;
                  add_a   <= a_next[NIB_W-1:0];
                  add_b   <= b_next[NIB_W-1:0];
                  chain_q <= 1'b1;
               end
            end
            DRAIN: begin
               sum_q       <= sum_shift;
               cout_q      <= add_cout;
               idx         <= '0;
               out_valid_q <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Bench for the nibble-serial CLA sequencer at WIDTH=16 and WIDTH=4, each paired with its adder.
module tb_cla_nibble_seq_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   cla_nibble_seq_ctrl_if #(.WIDTH(16)) bus16 ();
   cla_nibble_seq_ctrl_if #(.WIDTH(4))  bus4 ();

   logic [3:0] add_a16, add_b16, add_sum16;
   logic       add_cin16, add_cout16;
   logic [3:0] add_a4, add_b4, add_sum4;
   logic       add_cin4, add_cout4;

   cla_nibble_seq_ctrl #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16),
      .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
      .add_sum(add_sum16), .add_cout(add_cout16)
   );
   complete_circuit u_add16 (
      .clk(clk), .rst_n(rst_n), .a(add_a16), .b(add_b16), .cin(add_cin16),
      .sum(add_sum16), .cout(add_cout16)
   );

   cla_nibble_seq_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4),
      .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
      .add_sum(add_sum4), .add_cout(add_cout4)
   );
   complete_circuit u_add4 (
      .clk(clk), .rst_n(rst_n), .a(add_a4), .b(add_b4), .cin(add_cin4),
      .sum(add_sum4), .cout(add_cout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width sum, and the carry entering each nibble from the low-order bits.
   function automatic logic [16:0] model_add16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      return 17'(a) + 17'(b) + 17'(cin);
   endfunction

   function automatic logic [4:0] model_add4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      return 5'(a) + 5'(b) + 5'(cin);
   endfunction

   function automatic logic [3:0] model_carries(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < 4; k++) begin
         longint unsigned m;
         longint unsigned t;
         m    = (64'd1 << (4 * k)) - 64'd1;
         t    = (64'(a) & m) + (64'(b) & m) + 64'(cin);
         c[k] = t[4*k];
      end
      return c;
   endfunction

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input int pulse_at,
                       output logic [15:0] s, output logic co, output int lat,
                       output logic [15:0] aseq, output logic [3:0] cseq, output logic rdy_seen);
      int n;
      lat = -1; aseq = '0; cseq = '0; rdy_seen = 1'b0;
      @(negedge clk);
      n = 0;
      while (bus16.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus16.in_valid = 1'b1;
      bus16.in_a     = a;
      bus16.in_b     = b;
      bus16.in_cin   = cin;
      @(posedge clk);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (n == pulse_at) begin
            bus16.in_valid = 1'b1;
            bus16.in_a     = 16'hAAAA;
            bus16.in_b     = 16'hAAAA;
            bus16.in_cin   = 1'b1;
         end else begin
            bus16.in_valid = 1'b0;
            bus16.in_a     = 16'($urandom);
            bus16.in_b     = 16'($urandom);
            bus16.in_cin   = 1'($urandom);
         end
         if (n < 4) begin
            aseq[n*4 +: 4] = add_a16;
            cseq[n]        = add_cin16;
         end
         if (bus16.out_valid === 1'b1) begin
            lat = n;
            break;
         end
         if (bus16.in_ready !== 1'b0) rdy_seen = 1'b1;
      end
      bus16.in_valid = 1'b0;
      s  = bus16.out_sum;
      co = bus16.out_cout;
   endtask

   task automatic finish16();
      @(negedge clk);
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.out_ready = 1'b0;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      output logic [3:0] s, output logic co, output int lat);
      int n;
      lat = -1;
      @(negedge clk);
      n = 0;
      while (bus4.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus4.in_valid = 1'b1;
      bus4.in_a     = a;
      bus4.in_b     = b;
      bus4.in_cin   = cin;
      @(posedge clk);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         bus4.in_valid = 1'b0;
         if (bus4.out_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
      s  = bus4.out_sum;
      co = bus4.out_cout;
      @(negedge clk);
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 8;
      if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus16.in_ready); end
      if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus16.out_valid); end
      if (bus16.out_sum !== 16'h0) begin failures++; $display("FAIL reset_out_sum got=%h want=0000", bus16.out_sum); end
      if (bus16.out_cout !== 1'b0) begin failures++; $display("FAIL reset_out_cout got=%b want=0", bus16.out_cout); end
      if (add_a16 !== 4'h0) begin failures++; $display("FAIL reset_add_a got=%h want=0", add_a16); end
      if (add_b16 !== 4'h0) begin failures++; $display("FAIL reset_add_b got=%h want=0", add_b16); end
      if (add_cin16 !== 1'b0) begin failures++; $display("FAIL reset_add_cin got=%b want=0", add_cin16); end
      if (bus4.in_ready !== 1'b1) begin failures++; $display("FAIL reset_w4_in_ready got=%b want=1", bus4.in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [15:0] s, aseq; logic co, rdy; logic [3:0] cseq; int lat;
      op16(16'h1234, 16'h4321, 1'b0, -1, s, co, lat, aseq, cseq, rdy);
      checks += 5;
      if (s !== 16'h5555) begin failures++; $display("FAIL basic_sum got=%h want=5555", s); end
      if (co !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b want=0", co); end
      if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d want=5", lat); end
      if (aseq !== 16'h1234) begin failures++; $display("FAIL basic_add_a_seq got=%h want=1234", aseq); end
      if (rdy !== 1'b0) begin failures++; $display("FAIL basic_in_ready_busy got=%b want=0", rdy); end
      finish16();
      checks += 2;
      if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b want=0", bus16.out_valid); end
      if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b want=1", bus16.in_ready); end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] s, aseq; logic co, rdy; logic [3:0] cseq; int lat;
      op16(16'hFFFF, 16'h0001, 1'b0, -1, s, co, lat, aseq, cseq, rdy);
      checks += 3;
      if (s !== 16'h0000) begin failures++; $display("FAIL ripple_sum got=%h want=0000", s); end
      if (co !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b want=1", co); end
      if (cseq !== 4'b1110) begin failures++; $display("FAIL ripple_add_cin got=%b want=1110", cseq); end
      finish16();
   endtask

   task automatic test_no_stale_carry();
      logic [15:0] s, aseq; logic co, rdy; logic [3:0] cseq; int lat;
      op16(16'hFFFF, 16'hFFFF, 1'b1, -1, s, co, lat, aseq, cseq, rdy);
      checks += 3;
      if (s !== 16'hFFFF) begin failures++; $display("FAIL allones_sum got=%h want=ffff", s); end
      if (co !== 1'b1) begin failures++; $display("FAIL allones_cout got=%b want=1", co); end
      if (cseq !== 4'b1111) begin failures++; $display("FAIL allones_add_cin got=%b want=1111", cseq); end
      finish16();
      op16(16'h0000, 16'h0000, 1'b0, -1, s, co, lat, aseq, cseq, rdy);
      checks += 3;
      if (s !== 16'h0000) begin failures++; $display("FAIL zero_sum got=%h want=0000", s); end
      if (co !== 1'b0) begin failures++; $display("FAIL zero_cout got=%b want=0", co); end
      if (cseq !== 4'b0000) begin failures++; $display("FAIL zero_add_cin got=%b want=0000", cseq); end
      finish16();
   endtask

   task automatic test_backpressure();
      logic [15:0] s, aseq; logic co, rdy; logic [3:0] cseq; int lat;
      logic [16:0] exp;
      exp = model_add16(16'h8765, 16'h1234, 1'b1);
      op16(16'h8765, 16'h1234, 1'b1, -1, s, co, lat, aseq, cseq, rdy);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks += 4;
         if (bus16.out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b want=1", i, bus16.out_valid); end
         if (bus16.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", i, bus16.in_ready); end
         if (bus16.out_sum !== exp[15:0]) begin failures++; $display("FAIL hold_sum cyc=%0d got=%h want=%h", i, bus16.out_sum, exp[15:0]); end
         if (bus16.out_cout !== exp[16]) begin failures++; $display("FAIL hold_cout cyc=%0d got=%b want=%b", i, bus16.out_cout, exp[16]); end
      end
      finish16();
      op16(16'h1111, 16'h2222, 1'b0, 1, s, co, lat, aseq, cseq, rdy);
      checks += 3;
      if (s !== 16'h3333) begin failures++; $display("FAIL ignore_pulse_sum got=%h want=3333", s); end
      if (co !== 1'b0) begin failures++; $display("FAIL ignore_pulse_cout got=%b want=0", co); end
      if (lat !== 5) begin failures++; $display("FAIL ignore_pulse_latency got=%0d want=5", lat); end
      finish16();
      begin
         logic seen;
         seen = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (bus16.out_valid !== 1'b0) seen = 1'b1;
         end
         checks++;
         if (seen !== 1'b0) begin failures++; $display("FAIL ignore_pulse_extra_op got=%b want=0", seen); end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] s, aseq; logic co, rdy; logic [3:0] cseq; int lat;
      logic seen;
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.in_a     = 16'h5A5A;
      bus16.in_b     = 16'h3C3C;
      bus16.in_cin   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", bus16.in_ready); end
      if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", bus16.out_valid); end
      if (add_a16 !== 4'h0) begin failures++; $display("FAIL midrst_add_a got=%h want=0", add_a16); end
      if (add_b16 !== 4'h0) begin failures++; $display("FAIL midrst_add_b got=%h want=0", add_b16); end
      if (add_cin16 !== 1'b0) begin failures++; $display("FAIL midrst_add_cin got=%b want=0", add_cin16); end
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus16.out_valid !== 1'b0) seen = 1'b1;
      end
      checks += 2;
      if (seen !== 1'b0) begin failures++; $display("FAIL midrst_partial_result got=%b want=0", seen); end
      if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after got=%b want=1", bus16.in_ready); end
      op16(16'h0F0F, 16'h00F1, 1'b0, -1, s, co, lat, aseq, cseq, rdy);
      checks += 2;
      if (s !== 16'h1000) begin failures++; $display("FAIL midrst_fresh_sum got=%h want=1000", s); end
      if (co !== 1'b0) begin failures++; $display("FAIL midrst_fresh_cout got=%b want=0", co); end
      finish16();
   endtask

   task automatic test_random16();
      logic [15:0] a, b, s, aseq; logic cin, co, rdy; logic [3:0] cseq; int lat;
      logic [16:0] exp;
      for (int i = 0; i < 20; i++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         cin = 1'($urandom);
         exp = model_add16(a, b, cin);
         op16(a, b, cin, -1, s, co, lat, aseq, cseq, rdy);
         checks += 6;
         if (s !== exp[15:0]) begin failures++; $display("FAIL rand_sum a=%h b=%h cin=%b got=%h want=%h", a, b, cin, s, exp[15:0]); end
         if (co !== exp[16]) begin failures++; $display("FAIL rand_cout a=%h b=%h cin=%b got=%b want=%b", a, b, cin, co, exp[16]); end
         if (lat !== 5) begin failures++; $display("FAIL rand_latency got=%0d want=5", lat); end
         if (aseq !== a) begin failures++; $display("FAIL rand_add_a_seq got=%h want=%h", aseq, a); end
         if (cseq !== model_carries(a, b, cin)) begin failures++; $display("FAIL rand_add_cin got=%b want=%b", cseq, model_carries(a, b, cin)); end
         if (rdy !== 1'b0) begin failures++; $display("FAIL rand_in_ready_busy got=%b want=0", rdy); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         checks += 2;
         if (bus16.out_sum !== exp[15:0]) begin failures++; $display("FAIL rand_hold_sum got=%h want=%h", bus16.out_sum, exp[15:0]); end
         if (bus16.out_valid !== 1'b1) begin failures++; $display("FAIL rand_hold_valid got=%b want=1", bus16.out_valid); end
         finish16();
      end
   endtask

   task automatic test_width4();
      logic [3:0] a, b, s; logic cin, co; int lat;
      logic [4:0] exp;
      op4(4'hF, 4'hF, 1'b1, s, co, lat);
      checks += 3;
      if (s !== 4'hF) begin failures++; $display("FAIL w4_sum got=%h want=f", s); end
      if (co !== 1'b1) begin failures++; $display("FAIL w4_cout got=%b want=1", co); end
      if (lat !== 2) begin failures++; $display("FAIL w4_latency got=%0d want=2", lat); end
      for (int i = 0; i < 10; i++) begin
         a   = 4'($urandom);
         b   = 4'($urandom);
         cin = 1'($urandom);
         exp = model_add4(a, b, cin);
         op4(a, b, cin, s, co, lat);
         checks += 3;
         if (s !== exp[3:0]) begin failures++; $display("FAIL w4_rand_sum a=%h b=%h cin=%b got=%h want=%h", a, b, cin, s, exp[3:0]); end
         if (co !== exp[4]) begin failures++; $display("FAIL w4_rand_cout got=%b want=%b", co, exp[4]); end
         if (lat !== 2) begin failures++; $display("FAIL w4_rand_latency got=%0d want=2", lat); end
      end
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      bus16.in_valid  = 1'b0;
      bus16.in_a      = '0;
      bus16.in_b      = '0;
      bus16.in_cin    = 1'b0;
      bus16.out_ready = 1'b0;
      bus4.in_valid   = 1'b0;
      bus4.in_a       = '0;
      bus4.in_b       = '0;
      bus4.in_cin     = 1'b0;
      bus4.out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_carry_ripple();
      test_no_stale_carry();
      test_backpressure();
      test_reset_mid_op();
      test_random16();
      test_width4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
